seven_seg_scan: RTL

SEVEN_SEG_SCAN -- requirements
Module: seven_seg_scan

---
 rtl/seven_seg_scan_pkg.sv | 41 ++++
 rtl/seven_seg_scan_if.sv | 27 ++
 rtl/seven_seg_scan_hex_to_7seg.sv | 13 +
 rtl/seven_seg_scan.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/seven_seg_scan_pkg.sv
// Shared types and constants for the four-digit seven-segment scanner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seg7_pkg;

  // Slot phase: dark guard interval, then the digit is driven.
  typedef enum logic [0:0] {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } state_e;

  // All segments off (active-low).
  localparam logic [6:0] SEG_OFF = 7'h7F;
  // All anodes off (active-low).
  localparam logic [3:0] AN_OFF  = 4'hF;

  // Active-low segment patterns, entry i is the glyph for hex value i.
  // Listed from F (left) down to 0 (right) so that HEX_TABLE[i] picks glyph i.
  localparam logic [15:0][6:0] HEX_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

  // One complete display image: four hex digits, their decimal points and enables.
  typedef struct packed {
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  en;
  } disp_t;

  // Anode pattern with only the selected digit enabled (active-low).
  function automatic logic [3:0] an_select(input logic [1:0] idx);
    logic [3:0] r_sel;
    r_sel      = AN_OFF;
    r_sel[idx] = 1'b0;
    return r_sel;
  endfunction

endpackage

// File: rtl/seven_seg_scan_if.sv
// Display-content load bus and multiplexed LED drive lines of the scanner.
// Latency: n/a (wiring only).
// Backpressure: none; load is a fire-and-forget strobe.
interface seven_seg_scan_if;

  logic [15:0] digits;
  logic [3:0]  dp_in;
  logic [3:0]  digit_en;
  logic        load;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  // Side that supplies display content and watches the LED lines.
  modport master (
    output digits, dp_in, digit_en, load,
    input  an, seg, dp, frame_done
  );

  // The scanner itself.
  modport slave (
    input  digits, dp_in, digit_en, load,
    output an, seg, dp, frame_done
  );

endinterface

// File: rtl/seven_seg_scan_hex_to_7seg.sv
// Hex nibble to active-low seven-segment glyph decoder.
// Latency: combinational, zero cycles.
// Backpressure: none.
module hex_to_7seg
  import seg7_pkg::*;
(
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  assign o_seg = HEX_TABLE[i_hex];

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed 4-digit seven-segment scanner with double-buffered content.
// Latency: all LED outputs registered; new content appears at the next frame boundary.
// Backpressure: none; load is always accepted, last load before a frame boundary wins.
module seven_seg_scan
  import seg7_pkg::*;
#(
  parameter int TICK_DIV     = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic            clk,
  input  logic            rst_n,
  seven_seg_scan_if.slave bus
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

  // Slot timing
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_idx;
  state_e           r_state;

  // Double-buffered display content
  disp_t            r_pend;
  disp_t            r_act;
  logic             r_seen;

  // Registered LED drive
  logic [3:0]       r_an;
  logic [6:0]       r_seg;
  logic             r_dp;
  logic             r_frame_done;

  // Next-cycle values
  logic             w_wrap;
  logic             w_xfer;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [1:0]       w_idx_nxt;
  state_e           w_state_nxt;
  disp_t            w_in;
  logic [3:0]       w_hex;
  logic [6:0]       w_hex_seg;
  logic [3:0]       w_an_nxt;
  logic [6:0]       w_seg_nxt;
  logic             w_dp_nxt;
  logic             w_fd_nxt;

  assign w_wrap    = (r_cnt == CNT_LAST);
  // The digit-3 -> digit-0 wrap is the only point where the visible image may change.
  assign w_xfer    = w_wrap && (r_idx == 2'd3);
  assign w_cnt_nxt = w_wrap ? '0 : r_cnt + CNT_W'(1);
  assign w_idx_nxt = w_wrap ? r_idx + 2'd1 : r_idx;
  assign w_in      = '{digits: bus.digits, dp: bus.dp_in, en: bus.digit_en};

  // Slot counter and digit index advance together; the index steps on every wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= 2'd0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_idx <= w_idx_nxt;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= BLANK;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: dark guard at the head of every slot, then drive until the wrap.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      BLANK:   if (w_cnt_nxt == BLANK_END) w_state_nxt = DRIVE;
      DRIVE:   if (w_wrap)                 w_state_nxt = BLANK;
      default: w_state_nxt = BLANK;
    endcase
  end

  // Decode the digit that will be on display next cycle so the glyph can be registered.
  assign w_hex = r_act.digits[{w_idx_nxt, 2'b00} +: 4];

  hex_to_7seg u_hex (
    .i_hex (w_hex),
    .o_seg (w_hex_seg)
  );

  // FSM outputs: compute next-cycle LED drive from the next state and the active image.
  // The active image only changes on the transfer edge, after which the slot is in BLANK,
  // so reading the current active register here never shows a half-updated image.
  always_comb begin
    w_an_nxt  = AN_OFF;
    w_seg_nxt = SEG_OFF;
    w_dp_nxt  = 1'b1;
    if ((w_state_nxt == DRIVE) && r_act.en[w_idx_nxt]) begin
      w_an_nxt  = an_select(w_idx_nxt);
      w_seg_nxt = w_hex_seg;
      w_dp_nxt  = ~r_act.dp[w_idx_nxt];
    end
    // High during the final cycle of the digit-3 slot, i.e. the cycle ending on the transfer edge.
    w_fd_nxt  = (w_cnt_nxt == CNT_LAST) && (w_idx_nxt == 2'd3);
  end

  // LED drive registers, updated on the same edge as the counter and state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an         <= AN_OFF;
      r_seg        <= SEG_OFF;
      r_dp         <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_an         <= w_an_nxt;
      r_seg        <= w_seg_nxt;
      r_dp         <= w_dp_nxt;
      r_frame_done <= w_fd_nxt;
    end
  end

  // Content buffering: loads land in pending; pending moves to active only at frame wrap,
  // and a load on that very edge bypasses pending so it is not lost or delayed a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= '0;
      r_act  <= '0;
      r_seen <= 1'b0;
    end else if (w_xfer) begin
      if (bus.load) begin
        r_act <= w_in;
      end else if (r_seen) begin
        r_act <= r_pend;
      end
      r_seen <= 1'b0;
    end else if (bus.load) begin
      r_pend <= w_in;
      r_seen <= 1'b1;
    end
  end

  assign bus.an         = r_an;
  assign bus.seg        = r_seg;
  assign bus.dp         = r_dp;
  assign bus.frame_done = r_frame_done;

endmodule
